// File: rtl/microwave_ctrl.sv
// Microwave control FSM: turns keypad entry into BCD load pulses for the timer,
// sequences cook/pause/done, gates the magnetron and drives the completion alarm.
module microwave_ctrl #(
  parameter int unsigned MAX_DIGITS   = 3,
  parameter int unsigned ALARM_CYCLES = 50
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       start_key,
  input  logic       stop_key,
  input  logic       clr_key,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic       timer_clear,
  output logic       timer_load,
  output logic [3:0] timer_bcd,
  output logic       timer_stop,
  output logic       mag_on,
  output logic       done_alarm
);

  localparam int unsigned DigitW = $clog2(MAX_DIGITS + 1);
  localparam int unsigned AlarmW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
  localparam logic [DigitW-1:0] DigitMax  = DigitW'(MAX_DIGITS);
  localparam logic [AlarmW-1:0] AlarmLast = AlarmW'(ALARM_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StEntry, StCook, StPause, StDone} state_e;

  state_e              state_q;
  logic [DigitW-1:0]   digit_cnt_q;
  logic [AlarmW-1:0]   alarm_cnt_q;

  logic digit_ok;
  logic halt_req;
  logic can_start;
  logic any_key;

  always_comb begin
    digit_ok  = key_valid && (key_code <= 4'd9);
    halt_req  = stop_key || !door_closed;
    can_start = start_key && door_closed && !timer_zero;
    any_key   = key_valid || start_key || stop_key || clr_key;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= StIdle;
      digit_cnt_q <= '0;
      alarm_cnt_q <= '0;
      timer_stop  <= 1'b1;
      timer_clear <= 1'b0;
      timer_load  <= 1'b0;
      timer_bcd   <= 4'd0;
      mag_on      <= 1'b0;
      done_alarm  <= 1'b0;
    end else begin
      // Load and clear are single-cycle strobes.
      timer_load  <= 1'b0;
      timer_clear <= 1'b0;
      case (state_q)
        StIdle: begin
          timer_stop <= 1'b1;
          mag_on     <= 1'b0;
          if (clr_key) begin
            timer_clear <= 1'b1;
          end else if (digit_ok) begin
            timer_load  <= 1'b1;
            timer_bcd   <= key_code;
            digit_cnt_q <= DigitW'(1);
            state_q     <= StEntry;
          end
        end
        StEntry: begin
          if (clr_key) begin
            timer_clear <= 1'b1;
            digit_cnt_q <= '0;
            state_q     <= StIdle;
          end else if (can_start) begin
            timer_stop <= 1'b0;
            mag_on     <= 1'b1;
            state_q    <= StCook;
          end else if (digit_ok && (digit_cnt_q < DigitMax)) begin
            timer_load  <= 1'b1;
            timer_bcd   <= key_code;
            digit_cnt_q <= digit_cnt_q + DigitW'(1);
          end
        end
        StCook: begin
          if (clr_key) begin
            timer_clear <= 1'b1;
            timer_stop  <= 1'b1;
            mag_on      <= 1'b0;
            digit_cnt_q <= '0;
            state_q     <= StIdle;
          end else if (halt_req) begin
            timer_stop <= 1'b1;
            mag_on     <= 1'b0;
            state_q    <= StPause;
          end else if (timer_zero) begin
            timer_stop  <= 1'b1;
            mag_on      <= 1'b0;
            done_alarm  <= 1'b1;
            alarm_cnt_q <= '0;
            state_q     <= StDone;
          end
        end
        StPause: begin
          if (clr_key) begin
            timer_clear <= 1'b1;
            digit_cnt_q <= '0;
            state_q     <= StIdle;
          end else if (can_start) begin
            timer_stop <= 1'b0;
            mag_on     <= 1'b1;
            state_q    <= StCook;
          end
        end
        StDone: begin
          // Any key acknowledges the alarm early; otherwise it times out.
          if (any_key || (alarm_cnt_q == AlarmLast)) begin
            done_alarm  <= 1'b0;
            timer_clear <= 1'b1;
            digit_cnt_q <= '0;
            alarm_cnt_q <= '0;
            state_q     <= StIdle;
          end else begin
            alarm_cnt_q <= alarm_cnt_q + AlarmW'(1);
          end
        end
        default: begin
          timer_stop <= 1'b1;
          mag_on     <= 1'b0;
          done_alarm <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_microwave_ctrl.sv
// Directed self-checking bench for microwave_ctrl: entry, cook/done, pause,
// clear priority, zero-start refusal and asynchronous reset.
module tb_microwave_ctrl;

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       start_key = 1'b0;
  logic       stop_key = 1'b0;
  logic       clr_key = 1'b0;
  logic       door_closed = 1'b1;
  logic       timer_zero = 1'b0;
  logic       timer_clear;
  logic       timer_load;
  logic [3:0] timer_bcd;
  logic       timer_stop;
  logic       mag_on;
  logic       done_alarm;

  int unsigned vecs = 0;
  int unsigned errs = 0;

  microwave_ctrl #(.MAX_DIGITS(3), .ALARM_CYCLES(50)) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .start_key  (start_key),
    .stop_key   (stop_key),
    .clr_key    (clr_key),
    .door_closed(door_closed),
    .timer_zero (timer_zero),
    .timer_clear(timer_clear),
    .timer_load (timer_load),
    .timer_bcd  (timer_bcd),
    .timer_stop (timer_stop),
    .mag_on     (mag_on),
    .done_alarm (done_alarm)
  );

  always #5 clk = ~clk;

  task automatic press_key(input logic [3:0] code);
    @(negedge clk); key_valid = 1'b1; key_code = code;
    @(negedge clk); key_valid = 1'b0;
  endtask

  task automatic press(input logic s, input logic p, input logic c);
    @(negedge clk); start_key = s; stop_key = p; clr_key = c;
    @(negedge clk); start_key = 1'b0; stop_key = 1'b0; clr_key = 1'b0;
  endtask

  task automatic test_reset;
    clear_n = 1'b0;
    repeat (2) @(negedge clk);
    vecs++; if (timer_stop !== 1'b1) begin errs++; $display("FAIL rst_stop: got %b want 1", timer_stop); end
    vecs++; if (timer_clear !== 1'b0) begin errs++; $display("FAIL rst_clear: got %b want 0", timer_clear); end
    vecs++; if (timer_load !== 1'b0) begin errs++; $display("FAIL rst_load: got %b want 0", timer_load); end
    vecs++; if (timer_bcd !== 4'd0) begin errs++; $display("FAIL rst_bcd: got %0d want 0", timer_bcd); end
    vecs++; if (mag_on !== 1'b0) begin errs++; $display("FAIL rst_mag: got %b want 0", mag_on); end
    vecs++; if (done_alarm !== 1'b0) begin errs++; $display("FAIL rst_alarm: got %b want 0", done_alarm); end
    clear_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_entry;
    logic [3:0] codes [3];
    codes = '{4'd1, 4'd3, 4'd0};
    for (int i = 0; i < 3; i++) begin
      press_key(codes[i]);
      vecs++; if (timer_load !== 1'b1) begin errs++; $display("FAIL entry_load%0d: got %b want 1", i, timer_load); end
      vecs++; if (timer_bcd !== codes[i]) begin errs++; $display("FAIL entry_bcd%0d: got %0d want %0d", i, timer_bcd, codes[i]); end
      vecs++; if (timer_clear !== 1'b0) begin errs++; $display("FAIL entry_noclr%0d: got %b want 0", i, timer_clear); end
      @(negedge clk);
      vecs++; if (timer_load !== 1'b0) begin errs++; $display("FAIL entry_pulse%0d: got %b want 0", i, timer_load); end
    end
  endtask

  task automatic test_ignore;
    press_key(4'd7);
    vecs++; if (timer_load !== 1'b0) begin errs++; $display("FAIL ign_4th: got %b want 0", timer_load); end
    vecs++; if (timer_bcd !== 4'd0) begin errs++; $display("FAIL ign_bcd: got %0d want 0", timer_bcd); end
    press_key(4'd12);
    vecs++; if (timer_load !== 1'b0) begin errs++; $display("FAIL ign_code12: got %b want 0", timer_load); end
    press(1'b0, 1'b0, 1'b1);
    vecs++; if (timer_clear !== 1'b1) begin errs++; $display("FAIL ign_clr: got %b want 1", timer_clear); end
    vecs++; if (timer_load !== 1'b0) begin errs++; $display("FAIL ign_clr_noload: got %b want 0", timer_load); end
    @(negedge clk);
    vecs++; if (timer_clear !== 1'b0) begin errs++; $display("FAIL ign_clr_pulse: got %b want 0", timer_clear); end
    press_key(4'd12);
    vecs++; if (timer_load !== 1'b0) begin errs++; $display("FAIL ign_idle12: got %b want 0", timer_load); end
    press_key(4'd8);
    vecs++; if (timer_load !== 1'b1 || timer_bcd !== 4'd8) begin
      errs++; $display("FAIL ign_idle8: got load=%b bcd=%0d want load=1 bcd=8", timer_load, timer_bcd);
    end
    press(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back;
    @(negedge clk); key_valid = 1'b1; key_code = 4'd4;
    @(negedge clk); key_code = 4'd5;
    vecs++; if (timer_load !== 1'b1 || timer_bcd !== 4'd4) begin
      errs++; $display("FAIL b2b_first: got load=%b bcd=%0d want load=1 bcd=4", timer_load, timer_bcd);
    end
    @(negedge clk); key_valid = 1'b0;
    vecs++; if (timer_load !== 1'b1 || timer_bcd !== 4'd5) begin
      errs++; $display("FAIL b2b_second: got load=%b bcd=%0d want load=1 bcd=5", timer_load, timer_bcd);
    end
    @(negedge clk);
    vecs++; if (timer_load !== 1'b0 || timer_bcd !== 4'd5) begin
      errs++; $display("FAIL b2b_hold: got load=%b bcd=%0d want load=0 bcd=5", timer_load, timer_bcd);
    end
    press(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_cook_done;
    int n;
    timer_zero = 1'b0;
    press_key(4'd0); press_key(4'd0); press_key(4'd5);
    press(1'b1, 1'b0, 1'b0);
    vecs++; if (timer_stop !== 1'b0 || mag_on !== 1'b1) begin
      errs++; $display("FAIL cook_start: got stop=%b mag=%b want stop=0 mag=1", timer_stop, mag_on);
    end
    press_key(4'd6);
    vecs++; if (timer_load !== 1'b0) begin errs++; $display("FAIL cook_digit: got %b want 0", timer_load); end
    @(negedge clk); timer_zero = 1'b1;
    @(negedge clk);
    vecs++; if (mag_on !== 1'b0 || timer_stop !== 1'b1 || done_alarm !== 1'b1) begin
      errs++; $display("FAIL done_entry: got mag=%b stop=%b alarm=%b want 0 1 1", mag_on, timer_stop, done_alarm);
    end
    n = 0;
    while (done_alarm === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    vecs++; if (n != 50) begin errs++; $display("FAIL done_len: got %0d want 50", n); end
    vecs++; if (timer_clear !== 1'b1) begin errs++; $display("FAIL done_clr: got %b want 1", timer_clear); end
    @(negedge clk);
    vecs++; if (timer_clear !== 1'b0 || done_alarm !== 1'b0) begin
      errs++; $display("FAIL done_idle: got clr=%b alarm=%b want 0 0", timer_clear, done_alarm);
    end
    timer_zero = 1'b0;
  endtask

  task automatic test_door_pause;
    press_key(4'd2); press_key(4'd0);
    press(1'b1, 1'b0, 1'b0);
    vecs++; if (mag_on !== 1'b1) begin errs++; $display("FAIL door_cook: got %b want 1", mag_on); end
    @(negedge clk); door_closed = 1'b0;
    @(negedge clk);
    vecs++; if (mag_on !== 1'b0 || timer_stop !== 1'b1) begin
      errs++; $display("FAIL door_pause: got mag=%b stop=%b want 0 1", mag_on, timer_stop);
    end
    press(1'b1, 1'b0, 1'b0);
    vecs++; if (mag_on !== 1'b0) begin errs++; $display("FAIL door_open_start: got %b want 0", mag_on); end
    door_closed = 1'b1;
    press(1'b1, 1'b0, 1'b0);
    vecs++; if (mag_on !== 1'b1 || timer_stop !== 1'b0) begin
      errs++; $display("FAIL door_resume: got mag=%b stop=%b want 1 0", mag_on, timer_stop);
    end
    press(1'b0, 1'b1, 1'b0);
    vecs++; if (mag_on !== 1'b0 || timer_stop !== 1'b1) begin
      errs++; $display("FAIL stop_pause: got mag=%b stop=%b want 0 1", mag_on, timer_stop);
    end
    press(1'b1, 1'b0, 1'b0);
    vecs++; if (mag_on !== 1'b1) begin errs++; $display("FAIL stop_resume: got %b want 1", mag_on); end
  endtask

  task automatic test_clear_priority;
    press(1'b0, 1'b1, 1'b1);
    vecs++; if (timer_clear !== 1'b1 || mag_on !== 1'b0 || timer_stop !== 1'b1) begin
      errs++; $display("FAIL clr_prio: got clr=%b mag=%b stop=%b want 1 0 1", timer_clear, mag_on, timer_stop);
    end
    press(1'b1, 1'b0, 1'b0);
    vecs++; if (mag_on !== 1'b0) begin errs++; $display("FAIL idle_start: got %b want 0", mag_on); end
  endtask

  task automatic test_done_early;
    press_key(4'd1);
    press(1'b1, 1'b0, 1'b0);
    @(negedge clk); timer_zero = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    vecs++; if (done_alarm !== 1'b1) begin errs++; $display("FAIL early_alarm: got %b want 1", done_alarm); end
    press(1'b0, 1'b1, 1'b0);
    vecs++; if (done_alarm !== 1'b0 || timer_clear !== 1'b1) begin
      errs++; $display("FAIL early_ack: got alarm=%b clr=%b want 0 1", done_alarm, timer_clear);
    end
    timer_zero = 1'b0;
  endtask

  task automatic test_zero_start;
    press_key(4'd0); press_key(4'd0); press_key(4'd0);
    timer_zero = 1'b1;
    press(1'b1, 1'b0, 1'b0);
    vecs++; if (mag_on !== 1'b0 || timer_stop !== 1'b1) begin
      errs++; $display("FAIL zero_start: got mag=%b stop=%b want 0 1", mag_on, timer_stop);
    end
    press(1'b0, 1'b0, 1'b1);
    vecs++; if (timer_clear !== 1'b1) begin errs++; $display("FAIL zero_clr: got %b want 1", timer_clear); end
    timer_zero = 1'b0;
    press_key(4'd9);
    press(1'b1, 1'b0, 1'b0);
    vecs++; if (mag_on !== 1'b1) begin errs++; $display("FAIL arst_precook: got %b want 1", mag_on); end
    @(negedge clk);
    #2 clear_n = 1'b0;
    #1;
    vecs++; if (mag_on !== 1'b0 || timer_stop !== 1'b1 || timer_bcd !== 4'd0 || done_alarm !== 1'b0) begin
      errs++; $display("FAIL arst_async: got mag=%b stop=%b bcd=%0d alarm=%b want 0 1 0 0",
                       mag_on, timer_stop, timer_bcd, done_alarm);
    end
    @(negedge clk); clear_n = 1'b1;
    press(1'b1, 1'b0, 1'b0);
    vecs++; if (mag_on !== 1'b0) begin errs++; $display("FAIL arst_idle: got %b want 0", mag_on); end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_ignore();
    test_back_to_back();
    test_cook_done();
    test_door_pause();
    test_clear_priority();
    test_done_early();
    test_zero_start();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
